ascii_num_scanner: RTL

ASCII_NUM_SCANNER -- requirements
Module: ascii_num_scanner

---
 rtl/ascii_num_scanner.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/ascii_num_scanner.sv
// ascii_num_scanner: splits an ASCII byte stream into whitespace-separated
// tokens and forwards the digits of purely numeric tokens as binary beats.
// Each number starts with a clear beat, is followed by up to MAX_DIGITS
// digit beats, and is closed by a num_done pulse carrying its position in
// the current line and an error flag for overflowed or malformed numbers.
module ascii_num_scanner #(
   parameter int MAX_DIGITS = 5,
   parameter int IDX_W      = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [7:0]       in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [3:0]       num_data,
   output logic             num_valid,
   output logic             num_clear,
   output logic             num_done,
   output logic             num_err,
   output logic [IDX_W-1:0] num_index,
   output logic             line_end
);

   localparam int CNT_W = $clog2(MAX_DIGITS + 1);
   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_DIGITS);
   localparam logic [IDX_W-1:0] IDX_MAX = {IDX_W{1'b1}};

   typedef enum logic [1:0] {
      S_GAP  = 2'd0,
      S_WORD = 2'd1,
      S_NUM  = 2'd2
   } state_t;

   state_t           r_state;
   logic [CNT_W-1:0] r_cnt;
   logic             r_ovf;
   logic [IDX_W-1:0] r_idx;

   state_t           w_state_n;
   logic [CNT_W-1:0] w_cnt_n;
   logic             w_ovf_n;
   logic [IDX_W-1:0] w_idx_n;
   logic [IDX_W-1:0] w_idx_inc;
   logic [3:0]       w_data_n;
   logic             w_valid_n;
   logic             w_clear_n;
   logic             w_done_n;
   logic             w_err_n;
   logic [IDX_W-1:0] w_index_n;
   logic             w_line_end_n;

   logic w_is_digit;
   logic w_is_sep;
   logic w_is_eol;
   logic w_clr_ins;
   logic w_accept;

   assign w_is_digit = (in_data >= 8'h30) && (in_data <= 8'h39);
   assign w_is_sep   = (in_data == 8'h20) || (in_data == 8'h09);
   assign w_is_eol   = (in_data == 8'h0A) || (in_data == 8'h0D);

   // A digit arriving between tokens is held for one cycle so the clear beat
   // can go out ahead of it.
   assign w_clr_ins = !reset && (r_state == S_GAP) && in_valid && w_is_digit;
   assign in_ready  = !reset && !w_clr_ins;
   assign w_accept  = in_valid && in_ready;
   assign w_idx_inc = (r_idx == IDX_MAX) ? r_idx : (r_idx + IDX_W'(1));

   // Next-state and next-output decode for the token FSM.
   always_comb begin
      w_state_n    = r_state;
      w_cnt_n      = r_cnt;
      w_ovf_n      = r_ovf;
      w_idx_n      = r_idx;
      w_data_n     = 4'd0;
      w_valid_n    = 1'b0;
      w_clear_n    = 1'b0;
      w_done_n     = 1'b0;
      w_err_n      = 1'b0;
      w_index_n    = {IDX_W{1'b0}};
      w_line_end_n = 1'b0;
      if (w_clr_ins) begin
         w_state_n = S_NUM;
         w_cnt_n   = {CNT_W{1'b0}};
         w_ovf_n   = 1'b0;
         w_valid_n = 1'b1;
         w_clear_n = 1'b1;
      end else if (w_accept) begin
         case (r_state)
            S_GAP: begin
               if (w_is_eol) begin
                  w_line_end_n = 1'b1;
                  w_idx_n      = {IDX_W{1'b0}};
               end else if (w_is_sep) begin
                  w_state_n = S_GAP;
               end else begin
                  w_state_n = S_WORD;
               end
            end
            S_WORD: begin
               if (w_is_eol) begin
                  w_line_end_n = 1'b1;
                  w_idx_n      = {IDX_W{1'b0}};
                  w_state_n    = S_GAP;
               end else if (w_is_sep) begin
                  w_state_n = S_GAP;
               end else begin
                  w_state_n = S_WORD;
               end
            end
            S_NUM: begin
               if (w_is_digit) begin
                  if (r_cnt < MAX_CNT) begin
                     w_valid_n = 1'b1;
                     w_data_n  = in_data[3:0];
                     w_cnt_n   = r_cnt + CNT_W'(1);
                  end else begin
                     w_ovf_n = 1'b1;
                  end
               end else if (w_is_sep) begin
                  w_done_n  = 1'b1;
                  w_err_n   = r_ovf;
                  w_index_n = r_idx;
                  w_idx_n   = w_idx_inc;
                  w_state_n = S_GAP;
               end else if (w_is_eol) begin
                  w_done_n     = 1'b1;
                  w_err_n      = r_ovf;
                  w_index_n    = r_idx;
                  w_line_end_n = 1'b1;
                  w_idx_n      = {IDX_W{1'b0}};
                  w_state_n    = S_GAP;
               end else begin
                  w_done_n  = 1'b1;
                  w_err_n   = 1'b1;
                  w_index_n = r_idx;
                  w_idx_n   = w_idx_inc;
                  w_state_n = S_WORD;
               end
            end
            default: begin
               w_state_n = S_GAP;
            end
         endcase
      end else begin
         w_state_n = r_state;
      end
   end

   // State, counters and registered outputs with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= S_GAP;
         r_cnt     <= {CNT_W{1'b0}};
         r_ovf     <= 1'b0;
         r_idx     <= {IDX_W{1'b0}};
         num_data  <= 4'd0;
         num_valid <= 1'b0;
         num_clear <= 1'b0;
         num_done  <= 1'b0;
         num_err   <= 1'b0;
         num_index <= {IDX_W{1'b0}};
         line_end  <= 1'b0;
      end else begin
         r_state   <= w_state_n;
         r_cnt     <= w_cnt_n;
         r_ovf     <= w_ovf_n;
         r_idx     <= w_idx_n;
         num_data  <= w_data_n;
         num_valid <= w_valid_n;
         num_clear <= w_clear_n;
         num_done  <= w_done_n;
         num_err   <= w_err_n;
         num_index <= w_index_n;
         line_end  <= w_line_end_n;
      end
   end

endmodule
